// File: rtl/traffic_pkg.sv
// Shared constants and types for the signal conflict monitor.
package traffic_pkg;

    // Aspect encodings, one-hot; OFF is only ever driven to the lamps.
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] OFF = 3'b000;

    // Fault codes; a lower value takes priority when several fire at once.
    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_ILLEGAL   = 3'd1;
    localparam logic [2:0] FC_CONFLICT  = 3'd2;
    localparam logic [2:0] FC_GRN_TRUNC = 3'd3;
    localparam logic [2:0] FC_YEL_TRUNC = 3'd4;
    localparam logic [2:0] FC_BAD_TRANS = 3'd5;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } mon_state_t;

    // Only red->green, green->yellow and yellow->red are allowed changes.
    function automatic logic legal_step(input logic [2:0] from, input logic [2:0] to);
        return ((from == RED) && (to == GRN)) ||
               ((from == GRN) && (to == YEL)) ||
               ((from == YEL) && (to == RED));
    endfunction

endpackage

// File: rtl/flash_timer.sv
// Square-wave on/off toggle with FLASH_HALF cycles per half-period.
// A restart forces the "on" half and begins a fresh half-period.
module flash_timer #(
    parameter int FLASH_HALF = 4,
    parameter int CNT_W      = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_restart,
    input  logic i_en,
    output logic o_on
);

    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(FLASH_HALF - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_on;

    // Count cycles within the half-period and flip phase at its end.
    always_ff @(posedge clock) begin
        if (reset || i_restart) begin
            r_cnt <= '0;
            r_on  <= 1'b1;
        end else if (i_en) begin
            if (r_cnt == L_LAST) begin
                r_cnt <= '0;
                r_on  <= ~r_on;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_on = r_on;

endmodule

// File: rtl/signal_conflict_monitor.sv
// Safety monitor between the signal controller and the lamp drivers.
// Legal aspects are forwarded one cycle late; any violation latches a
// fault code and puts every approach on flashing yellow until cleared.
module signal_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = 8,
    parameter int MIN_YELLOW  = 4,
    parameter int STARTUP_CYC = 4,
    parameter int FLASH_HALF  = 4,
    parameter int CNT_W       = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] North_signal,
    input  logic [2:0] South_signal,
    input  logic [2:0] East_signal,
    input  logic [2:0] West_signal,
    input  logic       fault_clear,
    output logic [2:0] North_lamp,
    output logic [2:0] South_lamp,
    output logic [2:0] East_lamp,
    output logic [2:0] West_lamp,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam logic [CNT_W-1:0] L_MIN_GRN  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] L_MIN_YEL  = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] L_ST_LAST  = CNT_W'(STARTUP_CYC - 1);
    localparam logic [CNT_W-1:0] L_DWELL_MX = {CNT_W{1'b1}};

    // Index 0..3 = North, South, East, West.
    logic [3:0][2:0]  w_in;
    logic [3:0][2:0]  r_prev;
    logic [3:0][2:0]  r_lamp;
    mon_state_t       r_state;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] r_dwell;
    logic             r_prev_vld;
    logic             r_trunc_en;   // low until the first vector change
    logic [2:0]       r_code;

    logic             w_illegal, w_conflict, w_changed, w_prev_grn, w_prev_yel;
    logic             w_grn_trunc, w_yel_trunc, w_bad_trans;
    logic [2:0]       w_nonred;
    logic [2:0]       w_code;
    logic             w_flash_on;

    assign w_in      = {West_signal, East_signal, South_signal, North_signal};
    assign w_changed = (w_in != r_prev);

    // Evaluate every rule against the current sample; lowest code wins.
    always_comb begin
        w_illegal   = 1'b0;
        w_nonred    = '0;
        w_prev_grn  = 1'b0;
        w_prev_yel  = 1'b0;
        w_bad_trans = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((w_in[i] != GRN) && (w_in[i] != YEL) && (w_in[i] != RED))
                w_illegal = 1'b1;
            if (w_in[i] != RED)
                w_nonred = w_nonred + 3'd1;
            if (r_prev[i] == GRN) w_prev_grn = 1'b1;
            if (r_prev[i] == YEL) w_prev_yel = 1'b1;
            if ((w_in[i] != r_prev[i]) && !legal_step(r_prev[i], w_in[i]))
                w_bad_trans = r_prev_vld;
        end
        w_conflict  = (w_nonred > 3'd1);
        w_grn_trunc = r_prev_vld && r_trunc_en && w_changed && w_prev_grn && (r_dwell < L_MIN_GRN);
        w_yel_trunc = r_prev_vld && r_trunc_en && w_changed && w_prev_yel && (r_dwell < L_MIN_YEL);

        w_code = FC_NONE;
        if (w_illegal)        w_code = FC_ILLEGAL;
        else if (w_conflict)  w_code = FC_CONFLICT;
        else if (w_grn_trunc) w_code = FC_GRN_TRUNC;
        else if (w_yel_trunc) w_code = FC_YEL_TRUNC;
        else if (w_bad_trans) w_code = FC_BAD_TRANS;
    end

    // Monitor state machine, dwell tracking and forwarded lamp register.
    // STARTUP spans STARTUP_CYC edges; the next edge is the first sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_STARTUP;
            r_timer    <= '0;
            r_dwell    <= '0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_trunc_en <= 1'b0;
            r_lamp     <= {4{RED}};
            r_code     <= FC_NONE;
        end else begin
            case (r_state)
                ST_STARTUP: begin
                    if (r_timer == L_ST_LAST) begin
                        r_state <= ST_MONITOR;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_MONITOR: begin
                    if (w_code != FC_NONE) begin
                        r_state <= ST_FAULT;
                        r_code  <= w_code;
                    end else begin
                        r_lamp     <= w_in;
                        r_prev     <= w_in;
                        r_prev_vld <= 1'b1;
                        if (!r_prev_vld) begin
                            r_dwell    <= CNT_W'(1);
                            r_trunc_en <= 1'b0;
                        end else if (w_changed) begin
                            r_dwell    <= CNT_W'(1);
                            r_trunc_en <= 1'b1;
                        end else if (r_dwell != L_DWELL_MX) begin
                            r_dwell <= r_dwell + 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clear) begin
                        r_state    <= ST_STARTUP;
                        r_timer    <= '0;
                        r_dwell    <= '0;
                        r_prev_vld <= 1'b0;
                        r_trunc_en <= 1'b0;
                        r_lamp     <= {4{RED}};
                        r_code     <= FC_NONE;
                    end
                end
                default: r_state <= ST_STARTUP;
            endcase
        end
    end

    flash_timer #(
        .FLASH_HALF (FLASH_HALF),
        .CNT_W      (CNT_W)
    ) u_flash (
        .clock     (clock),
        .reset     (reset),
        .i_restart ((r_state == ST_MONITOR) && (w_code != FC_NONE)),
        .i_en      (r_state == ST_FAULT),
        .o_on      (w_flash_on)
    );

    assign fault      = (r_state == ST_FAULT);
    assign fault_code = r_code;
    assign North_lamp = fault ? (w_flash_on ? YEL : OFF) : r_lamp[0];
    assign South_lamp = fault ? (w_flash_on ? YEL : OFF) : r_lamp[1];
    assign East_lamp  = fault ? (w_flash_on ? YEL : OFF) : r_lamp[2];
    assign West_lamp  = fault ? (w_flash_on ? YEL : OFF) : r_lamp[3];

endmodule
